// File: rtl/axi_burst_pattern_writer.sv
// rtl/axi_burst_pattern_writer.sv - AXI4 write-only burst master writing an incrementing word pattern
// One burst in flight at a time: AW, then all W beats, then B, before the next AW.
module axi_burst_pattern_writer #(
  parameter int unsigned          C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0]          TARGET_BASE        = 32'h00080000,
  parameter int unsigned          BURST_LEN          = 16,
  parameter int unsigned          NUM_BURSTS         = 16,
  parameter logic [31:0]          PATTERN_SEED       = 32'h00000000
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          init_txn,
  output logic                          m_axi_txn_done,
  output logic                          m_axi_error,
  output logic                          busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);

  localparam int unsigned BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [8:0]  LAST_BEAT  = 9'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_M_AXI_ADDR_WIDTH'(BURST_LEN * 4);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = C_M_AXI_ADDR_WIDTH'(TARGET_BASE);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                        r_state,   w_state_nxt;
  logic                          r_init_q;
  logic                          r_awvalid, w_awvalid_nxt;
  logic                          r_wvalid,  w_wvalid_nxt;
  logic                          r_wlast,   w_wlast_nxt;
  logic                          r_bready,  w_bready_nxt;
  logic                          r_done,    w_done_nxt;
  logic                          r_error,   w_error_nxt;
  logic                          r_busy,    w_busy_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr,  w_awaddr_nxt;
  logic [31:0]                   r_word,    w_word_nxt;
  logic [8:0]                    r_beat,    w_beat_nxt;
  logic [BURST_W-1:0]            r_burst,   w_burst_nxt;
  logic                          w_start;

  // Only a fresh 0->1 edge of the CTRL level starts a run, and only when no run is active.
  assign w_start = init_txn && !r_init_q && (r_state == S_IDLE || r_state == S_DONE);

  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_wlast_nxt   = r_wlast;
    w_bready_nxt  = r_bready;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;
    w_busy_nxt    = r_busy;
    w_awaddr_nxt  = r_awaddr;
    w_word_nxt    = r_word;
    w_beat_nxt    = r_beat;
    w_burst_nxt   = r_burst;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_state_nxt   = S_AW;
          w_awvalid_nxt = 1'b1;
          w_done_nxt    = 1'b0;
          w_error_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
          w_burst_nxt   = '0;
          w_word_nxt    = '0;
          w_beat_nxt    = '0;
          w_awaddr_nxt  = BASE_ADDR;
        end
      end
      S_AW: begin
        if (M_AXI_AWREADY) begin
          w_state_nxt   = S_W;
          w_awvalid_nxt = 1'b0;
          w_wvalid_nxt  = 1'b1;
          w_beat_nxt    = '0;
          w_wlast_nxt   = (LAST_BEAT == 9'd0);
        end
      end
      S_W: begin
        if (M_AXI_WREADY) begin
          w_word_nxt  = r_word + 32'd1;
          w_beat_nxt  = r_beat + 9'd1;
          w_wlast_nxt = ((r_beat + 9'd1) == LAST_BEAT);
          if (r_wlast) begin
            w_state_nxt  = S_B;
            w_wvalid_nxt = 1'b0;
            w_wlast_nxt  = 1'b0;
            w_bready_nxt = 1'b1;
          end
        end
      end
      S_B: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) w_error_nxt = 1'b1;
          w_bready_nxt = 1'b0;
          w_awaddr_nxt = r_awaddr + ADDR_STEP;
          w_burst_nxt  = r_burst + 1'b1;
          if (r_burst == LAST_BURST) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt   = S_AW;
            w_awvalid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state   <= S_IDLE;
      r_init_q  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
      r_awaddr  <= BASE_ADDR;
      r_word    <= '0;
      r_beat    <= '0;
      r_burst   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_init_q  <= init_txn;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_wlast   <= w_wlast_nxt;
      r_bready  <= w_bready_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_busy    <= w_busy_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_word    <= w_word_nxt;
      r_beat    <= w_beat_nxt;
      r_burst   <= w_burst_nxt;
    end
  end

  assign m_axi_txn_done = r_done;
  assign m_axi_error    = r_error;
  assign busy           = r_busy;
  assign M_AXI_AWADDR   = r_awaddr;
  assign M_AXI_AWLEN    = 8'(BURST_LEN - 1);
  assign M_AXI_AWSIZE   = 3'b010;
  assign M_AXI_AWBURST  = 2'b01;
  assign M_AXI_AWCACHE  = 4'b0011;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_AWVALID  = r_awvalid;
  assign M_AXI_WDATA    = C_M_AXI_DATA_WIDTH'(PATTERN_SEED + r_word);
  assign M_AXI_WSTRB    = 4'hF;
  assign M_AXI_WLAST    = r_wlast;
  assign M_AXI_WVALID   = r_wvalid;
  assign M_AXI_BREADY   = r_bready;

endmodule

// File: tb/tb_axi_burst_pattern_writer.sv
// tb/tb_axi_burst_pattern_writer.sv - randomized bench for axi_burst_pattern_writer
// Instance 0 uses default parameters; instance 1 uses single-beat bursts with a wrapping seed.
module tb_axi_burst_pattern_writer;

  localparam logic [31:0] BASE = 32'h00080000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        init [2];
  logic        done [2];
  logic        err [2];
  logic        busy [2];
  logic [31:0] awaddr [2];
  logic [7:0]  awlen [2];
  logic [2:0]  awsize [2];
  logic [1:0]  awburst [2];
  logic [3:0]  awcache [2];
  logic [2:0]  awprot [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        wlast [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [1:0]  bresp [2];
  logic        bvalid [2];
  logic        bready [2];

  axi_burst_pattern_writer dut0 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .init_txn(init[0]),
    .m_axi_txn_done(done[0]), .m_axi_error(err[0]), .busy(busy[0]),
    .M_AXI_AWADDR(awaddr[0]), .M_AXI_AWLEN(awlen[0]), .M_AXI_AWSIZE(awsize[0]),
    .M_AXI_AWBURST(awburst[0]), .M_AXI_AWCACHE(awcache[0]), .M_AXI_AWPROT(awprot[0]),
    .M_AXI_AWVALID(awvalid[0]), .M_AXI_AWREADY(awready[0]),
    .M_AXI_WDATA(wdata[0]), .M_AXI_WSTRB(wstrb[0]), .M_AXI_WLAST(wlast[0]),
    .M_AXI_WVALID(wvalid[0]), .M_AXI_WREADY(wready[0]),
    .M_AXI_BRESP(bresp[0]), .M_AXI_BVALID(bvalid[0]), .M_AXI_BREADY(bready[0])
  );

  axi_burst_pattern_writer #(.BURST_LEN(1), .NUM_BURSTS(4), .PATTERN_SEED(32'hFFFFFFFE)) dut1 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .init_txn(init[1]),
    .m_axi_txn_done(done[1]), .m_axi_error(err[1]), .busy(busy[1]),
    .M_AXI_AWADDR(awaddr[1]), .M_AXI_AWLEN(awlen[1]), .M_AXI_AWSIZE(awsize[1]),
    .M_AXI_AWBURST(awburst[1]), .M_AXI_AWCACHE(awcache[1]), .M_AXI_AWPROT(awprot[1]),
    .M_AXI_AWVALID(awvalid[1]), .M_AXI_AWREADY(awready[1]),
    .M_AXI_WDATA(wdata[1]), .M_AXI_WSTRB(wstrb[1]), .M_AXI_WLAST(wlast[1]),
    .M_AXI_WVALID(wvalid[1]), .M_AXI_WREADY(wready[1]),
    .M_AXI_BRESP(bresp[1]), .M_AXI_BVALID(bvalid[1]), .M_AXI_BREADY(bready[1])
  );

  int          bl [2]   = '{16, 1};
  int          nb [2]   = '{16, 4};
  logic [31:0] seed [2] = '{32'h0, 32'hFFFFFFFE};

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int aw_p [2], w_p [2], b_p [2], aw_delay [2], err_burst [2], stall_beat [2], stall_left [2];
  int aw_cnt [2], w_cnt [2], b_cnt [2], proto [2], dlat_bad [2], aw_wait [2];
  int last_b_cyc [2], busy_rise_cyc [2];
  bit aw_open [2], b_pend [2];
  bit p_awv [2], p_awr [2], p_wv [2], p_wr [2], p_wl [2], p_done [2], p_busy [2];
  logic [31:0] p_awa [2], p_wd [2];
  logic [31:0] obs_aw [2][64];
  logic [31:0] obs_wd [2][512];
  logic        obs_wl [2][512];

  function automatic bit pick(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Reference: burst b at BASE + b*BL*4, global word k = seed + k, last flag on every BL-th beat.
  function automatic int model_mism(input int i);
    int m = 0;
    for (int b = 0; b < nb[i]; b++)
      if (obs_aw[i][b] !== BASE + 32'(b * bl[i] * 4)) m++;
    for (int k = 0; k < nb[i] * bl[i]; k++) begin
      if (obs_wd[i][k] !== seed[i] + 32'(k)) m++;
      if (obs_wl[i][k] !== ((k % bl[i]) == bl[i] - 1)) m++;
    end
    return m;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          awready[i] = 1'b0; wready[i] = 1'b0; bvalid[i] = 1'b0;
          p_awv[i] = 0; p_wv[i] = 0; p_done[i] = 0; p_busy[i] = 0;
          continue;
        end
        awready[i] = awvalid[i] && (aw_wait[i] >= aw_delay[i]) && pick(aw_p[i]);
        wready[i]  = pick(w_p[i]);
        if (wvalid[i] && w_cnt[i] == stall_beat[i] && stall_left[i] > 0) begin
          wready[i] = 1'b0;
          stall_left[i]--;
        end
        bvalid[i] = b_pend[i] && pick(b_p[i]);
        bresp[i]  = (b_cnt[i] == err_burst[i]) ? 2'b10 : 2'b00;
        if (p_awv[i] && !p_awr[i] && (!awvalid[i] || awaddr[i] !== p_awa[i])) proto[i]++;
        if (p_wv[i] && !p_wr[i] && (!wvalid[i] || wdata[i] !== p_wd[i] || wlast[i] !== p_wl[i])) proto[i]++;
        if (wvalid[i] && !aw_open[i]) proto[i]++;
        if (awvalid[i] && (awlen[i] !== 8'(bl[i] - 1) || awsize[i] !== 3'b010 || awburst[i] !== 2'b01 ||
                           awcache[i] !== 4'b0011 || awprot[i] !== 3'b000)) proto[i]++;
        if (awvalid[i] && (32'(awaddr[i][11:0]) + 32'(bl[i] * 4) > 32'd4096)) proto[i]++;
        if (wvalid[i] && wstrb[i] !== 4'hF) proto[i]++;
        if (busy[i] && done[i]) proto[i]++;
        if (awvalid[i] && awready[i]) begin
          if (aw_cnt[i] < 64) obs_aw[i][aw_cnt[i]] = awaddr[i];
          aw_cnt[i]++; aw_open[i] = 1; aw_wait[i] = 0;
        end else if (awvalid[i]) aw_wait[i]++;
        if (wvalid[i] && wready[i]) begin
          if (w_cnt[i] < 512) begin obs_wd[i][w_cnt[i]] = wdata[i]; obs_wl[i][w_cnt[i]] = wlast[i]; end
          w_cnt[i]++;
          if (wlast[i]) begin aw_open[i] = 0; b_pend[i] = 1; end
        end
        if (bvalid[i] && bready[i]) begin b_cnt[i]++; b_pend[i] = 0; last_b_cyc[i] = cyc; end
        if (done[i] && !p_done[i] && cyc != last_b_cyc[i] + 1) dlat_bad[i]++;
        if (busy[i] && !p_busy[i]) busy_rise_cyc[i] = cyc;
        p_awv[i] = awvalid[i]; p_awr[i] = awready[i]; p_awa[i] = awaddr[i];
        p_wv[i] = wvalid[i]; p_wr[i] = wready[i]; p_wd[i] = wdata[i]; p_wl[i] = wlast[i];
        p_done[i] = done[i]; p_busy[i] = busy[i];
      end
    end
  endtask

  task automatic knobs(input int i, input int ap, input int wp, input int bp, input int dly, input int eb);
    aw_p[i] = ap; w_p[i] = wp; b_p[i] = bp; aw_delay[i] = dly; err_burst[i] = eb;
    stall_beat[i] = -1; stall_left[i] = 0;
  endtask

  task automatic clr(input int i);
    aw_cnt[i] = 0; w_cnt[i] = 0; b_cnt[i] = 0; proto[i] = 0; dlat_bad[i] = 0; aw_wait[i] = 0;
    aw_open[i] = 0; b_pend[i] = 0; last_b_cyc[i] = -100; busy_rise_cyc[i] = -100;
  endtask

  task automatic pulse(input int i);
    @(negedge clk); init[i] = 1'b1;
    @(negedge clk); init[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output bit ok);
    ok = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done[i] === 1'b1) begin ok = 1; break; end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({awvalid[i], wvalid[i], bready[i], wlast[i], done[i], err[i], busy[i]} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d got %b want 0000000", i,
                 {awvalid[i], wvalid[i], bready[i], wlast[i], done[i], err[i], busy[i]});
      end
      n_vec++;
      if (awaddr[i] !== BASE) begin n_bad++; $display("FAIL reset_awaddr dut%0d got %h want %h", i, awaddr[i], BASE); end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_default_stream();
    bit ok;
    int m;
    knobs(0, 100, 100, 100, 0, -1); clr(0); pulse(0); wait_done(0, ok);
    m = model_mism(0);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL t1_done got %b want 1", done[0]); end
    n_vec++;
    if (aw_cnt[0] != 16 || w_cnt[0] != 256 || b_cnt[0] != 16) begin
      n_bad++; $display("FAIL t1_counts got aw=%0d w=%0d b=%0d want 16/256/16", aw_cnt[0], w_cnt[0], b_cnt[0]);
    end
    n_vec++; if (m != 0) begin n_bad++; $display("FAIL t1_pattern got %0d diffs want 0", m); end
    n_vec++; if (err[0] !== 1'b0 || busy[0] !== 1'b0) begin n_bad++; $display("FAIL t1_err_busy got %b%b want 00", err[0], busy[0]); end
    n_vec++;
    if (last_b_cyc[0] - busy_rise_cyc[0] != 16 * 18 - 1) begin
      n_bad++; $display("FAIL t1_latency got %0d want %0d", last_b_cyc[0] - busy_rise_cyc[0], 16 * 18 - 1);
    end
    n_vec++;
    if (proto[0] != 0 || dlat_bad[0] != 0) begin
      n_bad++; $display("FAIL t1_protocol got proto=%0d dlat=%0d want 0/0", proto[0], dlat_bad[0]);
    end
  endtask

  task automatic test_wready_stall();
    bit ok;
    int m;
    knobs(0, 100, 100, 100, 0, -1); clr(0);
    stall_beat[0] = 5; stall_left[0] = 3;
    pulse(0); wait_done(0, ok);
    m = model_mism(0);
    n_vec++;
    if (!ok || w_cnt[0] != 256 || m != 0) begin
      n_bad++; $display("FAIL t2_stream got ok=%0d beats=%0d diffs=%0d want 1/256/0", ok, w_cnt[0], m);
    end
    n_vec++;
    if (stall_left[0] != 0 || proto[0] != 0) begin
      n_bad++; $display("FAIL t2_hold got stall_left=%0d proto=%0d want 0/0", stall_left[0], proto[0]);
    end
    n_vec++;
    if (last_b_cyc[0] - busy_rise_cyc[0] != 16 * 18 + 2) begin
      n_bad++; $display("FAIL t2_latency got %0d want %0d", last_b_cyc[0] - busy_rise_cyc[0], 16 * 18 + 2);
    end
  endtask

  task automatic test_bresp_error();
    bit ok;
    knobs(0, 100, 100, 100, 0, 3); clr(0); pulse(0); wait_done(0, ok);
    n_vec++;
    if (!ok || err[0] !== 1'b1 || done[0] !== 1'b1) begin
      n_bad++; $display("FAIL t3_error got ok=%0d err=%b done=%b want 1/1/1", ok, err[0], done[0]);
    end
    n_vec++;
    if (aw_cnt[0] != 16 || b_cnt[0] != 16 || model_mism(0) != 0) begin
      n_bad++; $display("FAIL t3_bursts got aw=%0d b=%0d want 16/16", aw_cnt[0], b_cnt[0]);
    end
  endtask

  task automatic test_random_backpressure();
    bit ok;
    int eb, m;
    for (int r = 0; r < 3; r++) begin
      eb = int'($urandom_range(31));
      knobs(0, int'($urandom_range(100, 25)), int'($urandom_range(100, 25)), int'($urandom_range(100, 25)),
            int'($urandom_range(3)), eb);
      clr(0); pulse(0); wait_done(0, ok);
      m = model_mism(0);
      n_vec++;
      if (!ok || aw_cnt[0] != 16 || w_cnt[0] != 256 || b_cnt[0] != 16 || m != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_stream got ok=%0d aw=%0d w=%0d b=%0d diffs=%0d want 1/16/256/16/0",
                 r, ok, aw_cnt[0], w_cnt[0], b_cnt[0], m);
      end
      n_vec++;
      if (err[0] !== (eb < 16)) begin n_bad++; $display("FAIL rnd%0d_error got %b want %b", r, err[0], eb < 16); end
      n_vec++;
      if (proto[0] != 0 || dlat_bad[0] != 0) begin
        n_bad++; $display("FAIL rnd%0d_protocol got proto=%0d dlat=%0d want 0/0", r, proto[0], dlat_bad[0]);
      end
    end
  endtask

  task automatic test_restart();
    bit ok;
    knobs(0, 80, 80, 80, 0, -1); clr(0); pulse(0);
    for (int c = 0; c < 2000 && aw_cnt[0] < 3; c++) @(negedge clk);
    pulse(0);
    wait_done(0, ok);
    repeat (40) @(negedge clk);
    #1;
    n_vec++;
    if (!ok || aw_cnt[0] != 16 || done[0] !== 1'b1) begin
      n_bad++; $display("FAIL t4_busy_start got ok=%0d aw=%0d done=%b want 1/16/1", ok, aw_cnt[0], done[0]);
    end
    clr(0);
    @(negedge clk); init[0] = 1'b1;
    @(negedge clk); init[0] = 1'b0;
    #1;
    n_vec++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL t4_restart got done=%b busy=%b want 0/1", done[0], busy[0]);
    end
    wait_done(0, ok);
    n_vec++;
    if (!ok || aw_cnt[0] != 16 || model_mism(0) != 0) begin
      n_bad++; $display("FAIL t4_second_run got ok=%0d aw=%0d want 1/16", ok, aw_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit reached = 0;
    knobs(0, 100, 100, 100, 0, -1); clr(0); pulse(0);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (b_cnt[0] == 7 && w_cnt[0] >= 7 * 16 + 4) begin reached = 1; break; end
    end
    n_vec++; if (!reached) begin n_bad++; $display("FAIL t5_reach got b=%0d w=%0d want 7/>=116", b_cnt[0], w_cnt[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({awvalid[0], wvalid[0], bready[0], done[0], busy[0]} !== 5'b0) begin
      n_bad++; $display("FAIL t5_async got %b want 00000", {awvalid[0], wvalid[0], bready[0], done[0], busy[0]});
    end
    @(negedge clk); rst_n = 1'b1;
    clr(0); pulse(0); wait_done(0, ok);
    n_vec++;
    if (!ok || aw_cnt[0] != 16 || w_cnt[0] != 256 || model_mism(0) != 0 || err[0] !== 1'b0) begin
      n_bad++; $display("FAIL t5_rerun got ok=%0d aw=%0d w=%0d err=%b want 1/16/256/0", ok, aw_cnt[0], w_cnt[0], err[0]);
    end
  endtask

  task automatic test_single_beat();
    bit ok;
    int m;
    knobs(1, 100, 100, 100, 2, -1); clr(1); pulse(1); wait_done(1, ok);
    m = model_mism(1);
    n_vec++;
    if (!ok || aw_cnt[1] != 4 || w_cnt[1] != 4 || b_cnt[1] != 4) begin
      n_bad++; $display("FAIL t6_counts got ok=%0d aw=%0d w=%0d b=%0d want 1/4/4/4", ok, aw_cnt[1], w_cnt[1], b_cnt[1]);
    end
    n_vec++; if (m != 0) begin n_bad++; $display("FAIL t6_pattern got %0d diffs want 0", m); end
    n_vec++;
    if (last_b_cyc[1] - busy_rise_cyc[1] != 4 * 5 - 1 || proto[1] != 0 || dlat_bad[1] != 0) begin
      n_bad++; $display("FAIL t6_timing got lat=%0d proto=%0d dlat=%0d want 19/0/0",
                        last_b_cyc[1] - busy_rise_cyc[1], proto[1], dlat_bad[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      init[i] = 1'b0; awready[i] = 1'b0; wready[i] = 1'b0; bvalid[i] = 1'b0; bresp[i] = 2'b00;
      knobs(i, 100, 100, 100, 0, -1); clr(i);
      p_awv[i] = 0; p_awr[i] = 0; p_wv[i] = 0; p_wr[i] = 0; p_wl[i] = 0; p_done[i] = 0; p_busy[i] = 0;
      p_awa[i] = '0; p_wd[i] = '0;
    end
    fork
      monitor();
    join_none
    test_reset();
    test_default_stream();
    test_wready_stall();
    test_bresp_error();
    test_random_backpressure();
    test_restart();
    test_reset_mid();
    test_single_beat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
